// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronised UART receiver feeding a first-word fall-through FIFO.
// Define UART_RX_PARITY_EN to check a parity bit between the data and stop bits.
module uart_rx_fifo #(
    parameter int DIV        = 106,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rx,
    input  logic                         rd_en,
    input  logic                         clr_err,
    output logic [DATA_BITS-1:0]         rd_data,
    output logic                         rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]  count,
    output logic                         frame_err,
    output logic                         parity_err,
    output logic                         overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);
    localparam logic [2:0]    LAST = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state;
    logic                 sync1;
    logic                 rxs;
    logic                 rxs_d;
    logic [CW-1:0]        tick;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 bad;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wp;
    logic [AW-1:0]        rp;

    logic sample;
    logic stop_smp;
    logic push_req;
    logic fe_set;
    logic full;
    logic pop;
    logic push_ok;
    logic ovf_set;

    assign sample   = (tick == '0);
    assign stop_smp = (state == STOP) && sample;
    assign push_req = stop_smp && rxs && !bad;
    assign fe_set   = stop_smp && !rxs;
    assign full     = (count == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
    assign pop      = rd_en && rd_valid;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;

`ifdef UART_RX_PARITY_EN
    logic par_exp;
    logic pe_set;
    assign par_exp = (^shreg) ^ 1'(PARITY_ODD);
    assign pe_set  = (state == PARITY) && sample && (rxs != par_exp);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            sync1   <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
            tick    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            bad     <= 1'b0;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
            rxs_d <= rxs;
            if (state != IDLE)
                tick <= sample ? FULL : tick - 1'b1;
            unique case (state)
                IDLE: begin
                    if (rxs_d && !rxs) begin
                        state <= START;
                        tick  <= HALF;
                        bad   <= 1'b0;
                    end
                end
                START: begin
                    if (sample) begin
                        state   <= rxs ? IDLE : DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (sample) begin
                        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST)
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (sample) begin
                        bad   <= (rxs != par_exp);
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (sample)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= (frame_err & ~clr_err) | fe_set;
            overflow  <= (overflow & ~clr_err) | ovf_set;
`ifdef UART_RX_PARITY_EN
            parity_err <= (parity_err & ~clr_err) | pe_set;
`endif
            if (push_ok)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            if (push_ok && !pop)
                count <= count + 1'b1;
            else if (!push_ok && pop)
                count <= count - 1'b1;
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0 & 1'(PARITY_ODD);
`endif

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wp] <= shreg;
    end

    assign rd_valid = (count != '0);
    assign rd_data  = rd_valid ? mem[rp] : '0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frame-level checks of uart_rx_fifo.
// Frames are driven bit by bit; expected values are hand-computed constants.
module tb_uart_rx_fifo;

    localparam int DIV  = 106;
    localparam int PODD = 1;
`ifdef UART_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    localparam int STOP_CYC = DIV / 2 + 3 + DIV * (9 + NPAR);

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [4:0] count;
    logic       frame_err;
    logic       parity_err;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int rise_at;
    int pop_at = -1;
    int clr_stop = -1;

    uart_rx_fifo #(
        .DIV(DIV),
        .DATA_BITS(8),
        .FIFO_DEPTH(16),
        .PARITY_ODD(PODD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .rd_en(rd_en),
        .clr_err(clr_err),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .count(count),
        .frame_err(frame_err),
        .parity_err(parity_err),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic par_bad);
        logic [10:0] bits;
        int n;
        int cyc;
        bits = '0;
        for (int i = 0; i < 8; i++)
            bits[i+1] = d[i];
`ifdef UART_RX_PARITY_EN
        bits[9]  = (^d) ^ 1'(PODD) ^ par_bad;
        bits[10] = stop_bit;
        n = 11;
`else
        bits[9] = stop_bit;
        n = 10;
`endif
        rise_at = -1;
        cyc = 0;
        for (int b = 0; b < n; b++) begin
            rx = bits[b];
            repeat (DIV) begin
                @(negedge clk);
                cyc++;
                if (rise_at < 0 && rd_valid)
                    rise_at = cyc;
                rd_en = (cyc == pop_at - 1);
                if (cyc == clr_stop)
                    clr_err = 1'b0;
            end
        end
        rx = 1'b1;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 5'd0) begin
            errors++; $display("FAIL reset_count: got %0d want 0", count);
        end
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_head: got v=%b d=%h want 0/00", rd_valid, rd_data);
        end
        checks++;
        if ({frame_err, parity_err, overflow} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000",
                     {frame_err, parity_err, overflow});
        end
    endtask

    task automatic test_basic();
        send_frame(8'h55, 1'b1, 1'b0);
        checks++;
        if (rise_at !== STOP_CYC) begin
            errors++; $display("FAIL basic_latency: got %0d want %0d", rise_at, STOP_CYC);
        end
        checks++;
        if (rd_data !== 8'h55 || count !== 5'd1) begin
            errors++; $display("FAIL basic_data: got %h/%0d want 55/1", rd_data, count);
        end
        checks++;
        if ({frame_err, parity_err, overflow} !== 3'b000) begin
            errors++;
            $display("FAIL basic_flags: got %b want 000", {frame_err, parity_err, overflow});
        end
        pop_at = STOP_CYC;
        send_frame(8'h66, 1'b1, 1'b0);
        pop_at = -1;
        checks++;
        if (count !== 5'd1 || rd_data !== 8'h66) begin
            errors++; $display("FAIL push_pop_same: got %0d/%h want 1/66", count, rd_data);
        end
        pop_one();
        checks++;
        if (count !== 5'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL pop_empty: got %0d/%b/%h want 0/0/00", count, rd_valid, rd_data);
        end
        pop_one();
        checks++;
        if (count !== 5'd0) begin
            errors++; $display("FAIL pop_while_empty: got %0d want 0", count);
        end
    endtask

    task automatic test_false_start();
        rx = 1'b0;
        repeat (30) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        checks++;
        if (count !== 5'd0 || {frame_err, parity_err, overflow} !== 3'b000) begin
            errors++;
            $display("FAIL false_start: got cnt=%0d flags=%b want 0/000", count,
                     {frame_err, parity_err, overflow});
        end
        send_frame(8'h96, 1'b1, 1'b0);
        checks++;
        if (count !== 5'd1 || rd_data !== 8'h96) begin
            errors++; $display("FAIL after_false: got %0d/%h want 1/96", count, rd_data);
        end
        pop_one();
    endtask

    task automatic test_frame_err();
        send_frame(8'hA3, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        checks++;
        if (frame_err !== 1'b1 || count !== 5'd0) begin
            errors++; $display("FAIL frame_err_set: got %b/%0d want 1/0", frame_err, count);
        end
        pulse_clr();
        checks++;
        if (frame_err !== 1'b0) begin
            errors++; $display("FAIL frame_err_clr: got %b want 0", frame_err);
        end
        clr_err = 1'b1;
        clr_stop = STOP_CYC;
        send_frame(8'hA3, 1'b0, 1'b0);
        clr_stop = -1;
        checks++;
        if (frame_err !== 1'b1) begin
            errors++; $display("FAIL set_beats_clr: got %b want 1", frame_err);
        end
        pulse_clr();
        rx = 1'b0;
        repeat (1100) @(negedge clk);
        checks++;
        if (frame_err !== 1'b1) begin
            errors++; $display("FAIL break_err: got %b want 1", frame_err);
        end
        pulse_clr();
        repeat (2000) @(negedge clk);
        checks++;
        if (frame_err !== 1'b0 || count !== 5'd0) begin
            errors++; $display("FAIL break_single: got %b/%0d want 0/0", frame_err, count);
        end
        rx = 1'b1;
        repeat (300) @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        for (int i = 0; i < 17; i++)
            send_frame(8'(i), 1'b1, 1'b0);
        checks++;
        if (count !== 5'd16 || overflow !== 1'b1 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL overflow_full: got %0d/%b/%h want 16/1/00", count, overflow, rd_data);
        end
        pulse_clr();
        pop_at = STOP_CYC;
        send_frame(8'h11, 1'b1, 1'b0);
        pop_at = -1;
        checks++;
        if (overflow !== 1'b0 || count !== 5'd16) begin
            errors++; $display("FAIL full_push_pop: got %b/%0d want 0/16", overflow, count);
        end
        for (int k = 0; k < 16; k++) begin
            exp = (k < 15) ? 8'(k + 1) : 8'h11;
            checks++;
            if (rd_data !== exp) begin
                errors++; $display("FAIL order_%0d: got %h want %h", k, rd_data, exp);
            end
            pop_one();
        end
        checks++;
        if (count !== 5'd0 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL drained: got %0d/%b want 0/0", count, rd_valid);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        send_frame(8'h01, 1'b1, 1'b0);
        checks++;
        if (count !== 5'd1 || rd_data !== 8'h01 || parity_err !== 1'b0) begin
            errors++;
            $display("FAIL parity_good: got %0d/%h/%b want 1/01/0", count, rd_data, parity_err);
        end
        send_frame(8'h01, 1'b1, 1'b1);
        checks++;
        if (count !== 5'd1 || parity_err !== 1'b1) begin
            errors++; $display("FAIL parity_bad: got %0d/%b want 1/1", count, parity_err);
        end
        pop_one();
        pulse_clr();
    endtask
`endif

    task automatic test_reset_mid();
        send_frame(8'h77, 1'b1, 1'b0);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (4 * DIV) @(negedge clk);
        rx = 1'b0;
        repeat (DIV / 2) @(negedge clk);
        reset = 1'b1;
        rx = 1'b1;
        #1;
        checks++;
        if (count !== 5'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got %0d/%b/%h want 0/0/00", count, rd_valid, rd_data);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        send_frame(8'h3C, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        checks++;
        if (count !== 5'd1 || rd_data !== 8'h3C || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_resume: got %0d/%h/%b want 1/3C/0", count, rd_data, frame_err);
        end
    endtask

    initial begin
        rx = 1'b1;
        rd_en = 1'b0;
        clr_err = 1'b0;
        reset = 1'b0;
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_overflow();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
